jogador_automatico: RTL

//  Automatic player for the memory-challenge game: the opposite end of the game's LED/button interface.

---
 rtl/jogador_automatico.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: records the LED sequence shown each
// round and replays it on the buttons until the game reports win, loss or timeout.
module jogador_automatico #(
    parameter int MAX_SEQ = 16,
    parameter int QUIET   = 50,
    parameter int PRESS   = 20,
    parameter int GAP     = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ativar,
    input  logic       errar,
    input  logic [3:0] leds,
    input  logic       ganhou,
    input  logic       perdeu,
    input  logic       timeout,
    output logic [3:0] botoes,
    output logic       jogar,
    output logic       ocupado,
    output logic       venceu,
    output logic       falhou,
    output logic       overflow,
    output logic [2:0] db_estado,
    output logic [4:0] db_gravadas
);
    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        DISPARA   = 3'd1,
        OBSERVA   = 3'd2,
        PRESSIONA = 3'd3,
        SOLTA     = 3'd4,
        FIM       = 3'd5,
        ERRO      = 3'd6
    } estado_t;

    localparam int AW = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1;

    estado_t     estado_q, estado_d;
    logic [4:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [15:0] quiet_q, quiet_d, tmr_q, tmr_d;
    logic [3:0]  prev_q, prev_d;
    logic [3:0]  botoes_q, botoes_d;
    logic        jogar_q, jogar_d;
    logic        venceu_q, venceu_d, falhou_q, falhou_d, overflow_q, overflow_d;
    logic [3:0]  mem_q [MAX_SEQ];
    logic        cap_en, ovf_set, fim_ev, um_quente;
    logic [3:0]  lida, tecla;

    assign um_quente = (leds != 4'd0) && ((leds & (leds - 4'd1)) == 4'd0);
    assign fim_ev    = (ganhou | perdeu | timeout) &&
                       (estado_q inside {DISPARA, OBSERVA, PRESSIONA, SOLTA});

    // The final press of a round is rotated when errar is set, so it never matches.
    assign lida  = mem_q[rptr_q[AW-1:0]];
    assign tecla = (errar && (rptr_q == wptr_q - 5'd1)) ? {lida[2:0], lida[3]} : lida;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            wptr_q     <= 5'd0;
            rptr_q     <= 5'd0;
            quiet_q    <= 16'd0;
            tmr_q      <= 16'd0;
            prev_q     <= 4'd0;
            botoes_q   <= 4'd0;
            jogar_q    <= 1'b0;
            venceu_q   <= 1'b0;
            falhou_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            quiet_q    <= quiet_d;
            tmr_q      <= tmr_d;
            prev_q     <= prev_d;
            botoes_q   <= botoes_d;
            jogar_q    <= jogar_d;
            venceu_q   <= venceu_d;
            falhou_q   <= falhou_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (cap_en) mem_q[wptr_q[AW-1:0]] <= leds;
    end

    always_comb begin
        estado_d = estado_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        quiet_d  = quiet_q;
        tmr_d    = tmr_q;
        prev_d   = prev_q;
        cap_en   = 1'b0;
        ovf_set  = 1'b0;
        case (estado_q)
            OCIOSO: if (ativar) estado_d = DISPARA;
            DISPARA: begin
                wptr_d   = 5'd0;
                quiet_d  = 16'd0;
                prev_d   = 4'd0;
                estado_d = OBSERVA;
            end
            OBSERVA: begin
                prev_d = leds;
                // Garbage (multi-hot) values neither count as quiet nor break it.
                if (leds == 4'd0) begin
                    if (wptr_q != 5'd0) quiet_d = quiet_q + 16'd1;
                end else if (um_quente) begin
                    quiet_d = 16'd0;
                end
                if (um_quente && (leds != prev_q)) begin
                    if (wptr_q == 5'(MAX_SEQ)) begin
                        ovf_set  = 1'b1;
                        estado_d = ERRO;
                    end else begin
                        cap_en = 1'b1;
                        wptr_d = wptr_q + 5'd1;
                    end
                end else if (quiet_d == 16'(QUIET)) begin
                    rptr_d   = 5'd0;
                    tmr_d    = 16'd0;
                    estado_d = PRESSIONA;
                end
            end
            PRESSIONA: begin
                if (tmr_q == 16'(PRESS - 1)) begin
                    tmr_d    = 16'd0;
                    estado_d = SOLTA;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            SOLTA: begin
                if (tmr_q == 16'(GAP - 1)) begin
                    tmr_d  = 16'd0;
                    rptr_d = rptr_q + 5'd1;
                    if (rptr_q + 5'd1 == wptr_q) begin
                        wptr_d   = 5'd0;
                        quiet_d  = 16'd0;
                        prev_d   = 4'd0;
                        estado_d = OBSERVA;
                    end else begin
                        estado_d = PRESSIONA;
                    end
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            FIM, ERRO: if (!ativar) estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
        if (fim_ev) begin
            estado_d = FIM;
            cap_en   = 1'b0;
            ovf_set  = 1'b0;
        end
    end

    always_comb begin
        botoes_d   = 4'd0;
        if ((estado_q == PRESSIONA) && !fim_ev) botoes_d = tecla;
        jogar_d    = (estado_d == DISPARA);
        venceu_d   = venceu_q;
        falhou_d   = falhou_q;
        overflow_d = overflow_q | ovf_set;
        if (estado_d == OCIOSO) begin
            venceu_d   = 1'b0;
            falhou_d   = 1'b0;
            overflow_d = 1'b0;
        end
        if (fim_ev) begin
            venceu_d = ganhou;
            falhou_d = perdeu | timeout;
        end
    end

    assign botoes      = botoes_q;
    assign jogar       = jogar_q;
    assign venceu      = venceu_q;
    assign falhou      = falhou_q;
    assign overflow    = overflow_q;
    assign ocupado     = !((estado_q == OCIOSO) || (estado_q == FIM));
    assign db_estado   = estado_q;
    assign db_gravadas = wptr_q;
endmodule
